// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March C- RAM BIST initiator.
// Each march element has four attributes: address direction, ops per
// address, read-expect polarity and write polarity. They are encoded as
// bit vectors indexed by element number (M0 = bit 0 ... M5 = bit 5).
package ram_bist_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } bist_state_e;

    // 1 = element walks the addresses downwards (M3, M4, M5)
    localparam logic [5:0] ELEM_DOWN   = 6'b111000;
    // 1 = element does read then write per address (M1..M4); 0 = single op
    localparam logic [5:0] ELEM_TWO_OP = 6'b011110;
    // 1 = reads in this element expect ~BG (M2 r1, M4 r1)
    localparam logic [5:0] ELEM_RD_INV = 6'b010100;
    // 1 = writes in this element store ~BG (M1 w1, M3 w1)
    localparam logic [5:0] ELEM_WR_INV = 6'b001010;

    // Element number of a march state; non-march states map to 0.
    function automatic logic [2:0] elem_idx(input bist_state_e st);
        case (st)
            ST_M0:   elem_idx = 3'd0;
            ST_M1:   elem_idx = 3'd1;
            ST_M2:   elem_idx = 3'd2;
            ST_M3:   elem_idx = 3'd3;
            ST_M4:   elem_idx = 3'd4;
            ST_M5:   elem_idx = 3'd5;
            default: elem_idx = 3'd0;
        endcase
    endfunction

    // State following a march element once its last address is done.
    function automatic bist_state_e next_elem(input bist_state_e st);
        case (st)
            ST_M0:   next_elem = ST_M1;
            ST_M1:   next_elem = ST_M2;
            ST_M2:   next_elem = ST_M3;
            ST_M3:   next_elem = ST_M4;
            ST_M4:   next_elem = ST_M5;
            ST_M5:   next_elem = ST_DRAIN;
            default: next_elem = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// RAM port bundle between the BIST initiator (master) and the RAM (slave).
interface ram_march_bist_if
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_we,
        output mem_re,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_we,
        input  mem_re,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/ram_march_bist_addr_gen.sv
// Up/down address counter for the march elements: load jumps to the first
// address of an element (0 going up, all-ones going down), step moves one
// address in the current direction, last flags the final address.
module bist_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              load_down_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Next address: load has priority over step, otherwise hold
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_down_i ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
        end else if (step_i) begin
            addr_d = down_i ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == {ADDR_W{1'b0}}) : (addr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port synchronous RAM.
// All RAM port signals are registered. A read issued in cycle N returns
// data in cycle N+1, so the expected value is pipelined one cycle and the
// comparison happens whenever the previous cycle issued a read.
// Optional first-failure capture (fail_addr/fail_exp/fail_act) is built
// when RAM_BIST_FAIL_LOG_EN is defined; otherwise those ports are tied to 0.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    ram_march_bist_if.master        mem,
    output logic [ADDR_W-1:0]       fail_addr,
    output logic [DATA_W-1:0]       fail_exp,
    output logic [DATA_W-1:0]       fail_act
);
    bist_state_e       state_q, state_d, nxt_s;
    logic              phase_q, phase_d;       // 0 = read slot, 1 = write slot
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;
    logic              chk_q, chk_d;           // last cycle issued a read
    logic [DATA_W-1:0] chk_exp_q, chk_exp_d;

    logic [2:0]        cur_idx_s, nxt_idx_s;
    logic              down_s, last_s, load_s, load_down_s, step_s;
    logic              mismatch_s, start_acc_s;
    logic [DATA_W-1:0] wr_pat_s;
    logic [ADDR_W-1:0] addr_s;

    assign cur_idx_s   = elem_idx(state_q);
    assign nxt_s       = next_elem(state_q);
    assign nxt_idx_s   = elem_idx(nxt_s);
    assign down_s      = ELEM_DOWN[cur_idx_s];
    assign wr_pat_s    = ELEM_WR_INV[cur_idx_s] ? ~BG : BG;
    assign start_acc_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .load_down_i(load_down_s),
        .step_i     (step_s),
        .down_i     (down_s),
        .addr_o     (addr_s),
        .last_o     (last_s)
    );

    // Compare the data returned for the read issued in the previous cycle
    always_comb begin
        if (chk_q) begin
            mismatch_s = (mem.mem_dout != chk_exp_q);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // March sequencer: next state, next RAM operation and status
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        din_d       = {DATA_W{1'b0}};
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q | mismatch_s;
        load_s      = 1'b0;
        load_down_s = 1'b0;
        step_s      = 1'b0;
        chk_d       = re_q;
        chk_exp_d   = ELEM_RD_INV[cur_idx_s] ? ~BG : BG;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    state_d = ST_M0;
                    phase_d = 1'b0;
                    we_d    = 1'b1;
                    din_d   = BG;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 1'b0;
                    load_s  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_M0: begin
                if (last_s) begin
                    state_d     = nxt_s;
                    phase_d     = 1'b0;
                    re_d        = 1'b1;
                    load_s      = 1'b1;
                    load_down_s = ELEM_DOWN[nxt_idx_s];
                end else begin
                    step_s = 1'b1;
                    we_d   = 1'b1;
                    din_d  = BG;
                end
            end
            ST_M1, ST_M2, ST_M3, ST_M4: begin
                if (!phase_q) begin
                    // Write slot follows the read at the same address
                    phase_d = 1'b1;
                    we_d    = 1'b1;
                    din_d   = wr_pat_s;
                end else begin
                    phase_d = 1'b0;
                    re_d    = 1'b1;
                    if (last_s) begin
                        state_d     = nxt_s;
                        load_s      = 1'b1;
                        load_down_s = ELEM_DOWN[nxt_idx_s];
                    end else begin
                        step_s = 1'b1;
                    end
                end
            end
            ST_M5: begin
                if (last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    step_s = 1'b1;
                    re_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Final compare (address 0 of M5) folds straight into pass
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = ~(err_q | mismatch_s);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Sequencer and RAM-port registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            din_q     <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            chk_q     <= 1'b0;
            chk_exp_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            we_q      <= we_d;
            re_q      <= re_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            chk_q     <= chk_d;
            chk_exp_q <= chk_exp_d;
        end
    end

    assign mem.mem_we   = we_q;
    assign mem.mem_re   = re_q;
    assign mem.mem_addr = addr_s;
    assign mem.mem_din  = din_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;

`ifdef RAM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_act_q, fail_act_d;

    // Capture only the first mismatch of a run; a new run clears the log
    always_comb begin
        chk_addr_d  = addr_s;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        if (start_acc_s) begin
            fail_addr_d = {ADDR_W{1'b0}};
            fail_exp_d  = {DATA_W{1'b0}};
            fail_act_d  = {DATA_W{1'b0}};
        end else if (mismatch_s && !err_q) begin
            fail_addr_d = chk_addr_q;
            fail_exp_d  = chk_exp_q;
            fail_act_d  = mem.mem_dout;
        end else begin
            fail_addr_d = fail_addr_q;
        end
    end

    // First-failure log registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_addr_q  <= {ADDR_W{1'b0}};
            fail_addr_q <= {ADDR_W{1'b0}};
            fail_exp_q  <= {DATA_W{1'b0}};
            fail_act_q  <= {DATA_W{1'b0}};
        end else begin
            chk_addr_q  <= chk_addr_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
`else
    assign fail_addr = {ADDR_W{1'b0}};
    assign fail_exp  = {DATA_W{1'b0}};
    assign fail_act  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (BG=8'h00 and BG=8'hA5), each
// with its own 16x8 RAM model. Stimulus pushes the expected RAM-port trace
// and the expected end-of-run result into per-instance queues; a monitor
// on the falling edge pops and compares them.
module tb_ram_march_bist;

    localparam int BUSY_CYCLES = 161;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] din;
    } op_t;

    typedef struct packed {
        logic       pass;
        logic [3:0] fa;
        logic [7:0] fe;
        logic [7:0] fact;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic fault_en;

    logic       busy_s [2];
    logic       done_s [2];
    logic       pass_s [2];
    logic [3:0] fa_s   [2];
    logic [7:0] fe_s   [2];
    logic [7:0] fact_s [2];
    logic       we_s   [2];
    logic       re_s   [2];
    logic [3:0] addr_s [2];
    logic [7:0] din_s  [2];

    ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus0 ();
    ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus1 ();

    ram_march_bist #(.ADDR_W(4), .DATA_W(8), .BG(8'h00)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .mem(bus0.master),
        .fail_addr(fa_s[0]), .fail_exp(fe_s[0]), .fail_act(fact_s[0])
    );

    ram_march_bist #(.ADDR_W(4), .DATA_W(8), .BG(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .mem(bus1.master),
        .fail_addr(fa_s[1]), .fail_exp(fe_s[1]), .fail_act(fact_s[1])
    );

    assign we_s[0] = bus0.mem_we;  assign re_s[0] = bus0.mem_re;
    assign addr_s[0] = bus0.mem_addr; assign din_s[0] = bus0.mem_din;
    assign we_s[1] = bus1.mem_we;  assign re_s[1] = bus1.mem_re;
    assign addr_s[1] = bus1.mem_addr; assign din_s[1] = bus1.mem_din;

    // RAM models: registered read, dout zero unless a lone read; RAM 0 can
    // have bit 0 of address 5 stuck at 1.
    logic [7:0] ram0 [16];
    logic [7:0] ram1 [16];
    logic [7:0] dout0, dout1;

    always @(posedge clk) begin
        if (bus0.mem_we && !bus0.mem_re) ram0[bus0.mem_addr] <= bus0.mem_din;
        if (bus0.mem_re && !bus0.mem_we)
            dout0 <= ram0[bus0.mem_addr] | ((fault_en && bus0.mem_addr == 4'd5) ? 8'h01 : 8'h00);
        else
            dout0 <= 8'h00;
        if (bus1.mem_we && !bus1.mem_re) ram1[bus1.mem_addr] <= bus1.mem_din;
        if (bus1.mem_re && !bus1.mem_we) dout1 <= ram1[bus1.mem_addr];
        else dout1 <= 8'h00;
    end
    assign bus0.mem_dout = dout0;
    assign bus1.mem_dout = dout1;

    initial forever #5 clk = ~clk;

    int   nchk = 0;
    int   nerr = 0;
    op_t  op_q  [2][$];
    res_t res_q [2][$];
    int   cnt   [2];
    logic dprev [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected March C- trace for one run plus its end-of-run result
    task automatic push_run(input int k, input logic [7:0] bg, input logic p,
                            input logic [3:0] fa, input logic [7:0] fe, input logic [7:0] fact);
        logic [7:0] wv;
        logic [3:0] a;
        res_t r;
        for (int i = 0; i < 16; i++) op_q[k].push_back({1'b1, 1'b0, 4'(i), bg});
        for (int e = 1; e <= 4; e++) begin
            wv = (e == 1 || e == 3) ? ~bg : bg;
            for (int i = 0; i < 16; i++) begin
                a = (e >= 3) ? 4'(15 - i) : 4'(i);
                op_q[k].push_back({1'b0, 1'b1, a, 8'h00});
                op_q[k].push_back({1'b1, 1'b0, a, wv});
            end
        end
        for (int i = 0; i < 16; i++) op_q[k].push_back({1'b0, 1'b1, 4'(15 - i), 8'h00});
        op_q[k].push_back({1'b0, 1'b0, 4'd0, 8'h00});
        r.pass = p;
`ifdef RAM_BIST_FAIL_LOG_EN
        r.fa = fa; r.fe = fe; r.fact = fact;
`else
        r.fa = 4'd0; r.fe = 8'h00; r.fact = 8'h00;
        if (fa != 4'd0 || fe != 8'h00 || fact != 8'h00) r.fa = 4'd0;
`endif
        res_q[k].push_back(r);
    endtask

    task automatic push_clean_runs();
        push_run(0, 8'h00, 1'b1, 4'd0, 8'h00, 8'h00);
        push_run(1, 8'hA5, 1'b1, 4'd0, 8'h00, 8'h00);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_s[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor: compares every RAM-port cycle while busy and the result at done
    always @(negedge clk) begin
        op_t  o;
        res_t r;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                op_q[k].delete();
                res_q[k].delete();
                cnt[k]   = 0;
                dprev[k] = 1'b0;
            end else begin
                if (busy_s[k]) begin
                    cnt[k]++;
                    check($sformatf("we_re_excl%0d", k), 32'(we_s[k] & re_s[k]), 32'd0);
                    if (op_q[k].size() == 0) begin
                        check($sformatf("op_unexpected%0d", k), 32'd1, 32'd0);
                    end else begin
                        o = op_q[k].pop_front();
                        check($sformatf("op%0d", k),
                              32'({we_s[k], re_s[k], ((we_s[k] | re_s[k]) ? addr_s[k] : 4'd0), din_s[k]}),
                              32'(o));
                    end
                end
                if (done_s[k] && !dprev[k]) begin
                    check($sformatf("busy_len%0d", k), 32'(cnt[k]), 32'(BUSY_CYCLES));
                    cnt[k] = 0;
                    if (res_q[k].size() == 0) begin
                        check($sformatf("res_unexpected%0d", k), 32'd1, 32'd0);
                    end else begin
                        r = res_q[k].pop_front();
                        check($sformatf("pass%0d", k), 32'(pass_s[k]), 32'(r.pass));
                        check($sformatf("fail_addr%0d", k), 32'(fa_s[k]), 32'(r.fa));
                        check($sformatf("fail_exp%0d", k), 32'(fe_s[k]), 32'(r.fe));
                        check($sformatf("fail_act%0d", k), 32'(fact_s[k]), 32'(r.fact));
                    end
                end
                dprev[k] = done_s[k];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        fault_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 32'(busy_s[k]), 32'd0);
            check("rst_done", 32'(done_s[k]), 32'd0);
            check("rst_pass", 32'(pass_s[k]), 32'd0);
            check("rst_we_re", 32'({we_s[k], re_s[k]}), 32'd0);
            check("rst_fail", 32'({fa_s[k], fe_s[k], fact_s[k]}), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        // Plain runs: full trace, 161 busy cycles, pass
        push_clean_runs();
        pulse_start();
        wait_done("run1");
        repeat (3) @(negedge clk);
        check("done_held", 32'(done_s[0]), 32'd1);
        check("pass_held", 32'(pass_s[0]), 32'd1);

        // Stuck-at-1 on bit 0 of address 5 (instance 0 only)
        fault_en = 1'b1;
        push_run(0, 8'h00, 1'b0, 4'd5, 8'h00, 8'h01);
        push_run(1, 8'hA5, 1'b1, 4'd0, 8'h00, 8'h00);
        pulse_start();
        wait_done("fault");
        repeat (2) @(negedge clk);
        check("fault_pass_held", 32'(pass_s[0]), 32'd0);
        fault_en = 1'b0;

        // Reset 50 cycles into a run
        push_clean_runs();
        pulse_start();
        repeat (49) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("arst_we", 32'(we_s[k]), 32'd0);
            check("arst_re", 32'(re_s[k]), 32'd0);
            check("arst_busy", 32'(busy_s[k]), 32'd0);
            check("arst_done", 32'(done_s[k]), 32'd0);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        push_clean_runs();
        pulse_start();
        wait_done("after_rst");

        // start pulse at cycle 20 is ignored
        push_clean_runs();
        pulse_start();
        repeat (18) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignored_start");

        // start held high: DONE for exactly one cycle, then a new run
        push_clean_runs();
        push_clean_runs();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        wait_done("held1");
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("held_done_1cyc", 32'(done_s[k]), 32'd0);
            check("held_rebusy", 32'(busy_s[k]), 32'd1);
        end
        @(posedge clk); #1 start = 1'b0;
        wait_done("held2");
        repeat (3) @(negedge clk);
        check("idle_after_held", 32'(busy_s[0]), 32'd0);

        for (int k = 0; k < 2; k++) begin
            check("ops_left", 32'(op_q[k].size()), 32'd0);
            check("res_left", 32'(res_q[k].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
